// File: rtl/weight_fifo_bank.sv
`default_nettype none
// weight_fifo_bank: per-lane circular weight buffers drained into the PE array
// with a one-cycle-per-lane diagonal skew and zero-filled idle slots. Rev 1.0
module weight_fifo_bank #(
  parameter int LANES  = 16,
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [LANES-1:0]             push_en_i,
  input  logic [LANES-1:0][DATA_W-1:0] push_data_i,
  input  logic                         pop_start_i,
  output logic [LANES-1:0][DATA_W-1:0] out_data_o,
  output logic [LANES-1:0]             out_valid_o,
  output logic [LANES-1:0]             full_o,
  output logic [LANES-1:0]             empty_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic [LANES-1:0]             overflow_o,
  output logic [LANES-1:0]             underflow_o
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int DC_W  = $clog2(DEPTH + LANES);
  localparam logic [DC_W-1:0] DC_LAST = DC_W'(DEPTH + LANES - 2);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [DC_W-1:0] drain_cnt_q, drain_cnt_d;
  logic            done_q, done_d;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      drain_cnt_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pop_start_i) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = '0;
        end
      end
      default: begin
        if (drain_cnt_q == DC_LAST) begin
          state_d     = ST_IDLE;
          drain_cnt_d = '0;
        end else begin
          drain_cnt_d = drain_cnt_q + DC_W'(1);
        end
      end
    endcase
  end

  // done is registered so it lands with the last lane's final output word
  always_comb begin
    busy_o = (state_q == ST_DRAIN);
    done_d = (state_q == ST_DRAIN) && (drain_cnt_q == DC_LAST);
  end

  assign done_o = done_q;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;
    logic [DC_W-1:0]   rel;
    logic              sched, full, empty, push_ok, pop_ok;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    // Unsigned wrap makes cycles before this lane's window compare as >= DEPTH
    assign rel   = drain_cnt_q - DC_W'(gi);
    assign sched = busy_o && (rel < DC_W'(DEPTH));
    assign pop_ok  = sched && !empty;
    // A full lane being popped this cycle frees the slot the push lands in
    assign push_ok = push_en_i[gi] && (!full || pop_ok);

    always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      out_data_d  = '0;
      out_valid_d = pop_ok;
      ovf_d       = ovf_q | (push_en_i[gi] && full && !pop_ok);
      udf_d       = udf_q | (sched && empty);
      if (push_ok) begin
        wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr_d   = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        out_data_d = mem_q[rd_ptr_q];
      end
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end

    always_ff @(posedge clk) begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_data_i[gi];
      end
    end

    always_ff @(posedge clk) begin
      if (!rstn) begin
        wr_ptr_q    <= '0;
        rd_ptr_q    <= '0;
        count_q     <= '0;
        out_data_q  <= '0;
        out_valid_q <= 1'b0;
        ovf_q       <= 1'b0;
        udf_q       <= 1'b0;
      end else begin
        wr_ptr_q    <= wr_ptr_d;
        rd_ptr_q    <= rd_ptr_d;
        count_q     <= count_d;
        out_data_q  <= out_data_d;
        out_valid_q <= out_valid_d;
        ovf_q       <= ovf_d;
        udf_q       <= udf_d;
      end
    end

    assign out_data_o[gi]  = out_data_q;
    assign out_valid_o[gi] = out_valid_q;
    assign full_o[gi]      = full;
    assign empty_o[gi]     = empty;
    assign overflow_o[gi]  = ovf_q;
    assign underflow_o[gi] = udf_q;
  end

endmodule
`default_nettype wire

// File: doc/weight_fifo_bank.md
# weight_fifo_bank

Per-lane weight storage between the weight-FIFO input controller and the systolic PE array. Each lane captures one weight word per cycle from weight memory read data while the controller's lane enable is high. On a drain command, the bank replays its contents into the array with a diagonal skew: lane i starts i cycles after lane 0, and non-valid slots are zero-filled.

## Interface
Parameters:
- LANES, 16, number of lanes; matches the controller's lane count
- DEPTH, 16, entries per lane; one controller burst fills exactly DEPTH entries
- DATA_W, 8, weight word width
- CNT_W (localparam), $clog2(DEPTH)+1, occupancy counter width

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous, active-low reset
- push_en  in  LANES  per-lane write enable; driven by the controller's lane-enable output
- push_data  in  LANES x DATA_W  per-lane write data from weight memory read port
- pop_start  in  1  drain request; accepted only in IDLE
- out_data  out  LANES x DATA_W  registered skewed weights to the array; 0 when the lane is not valid
- out_valid  out  LANES  registered per-lane valid
- full  out  LANES  count == DEPTH (combinational from registered count)
- empty  out  LANES  count == 0 (combinational from registered count)
- busy  out  1  state == DRAIN
- done  out  1  one-cycle pulse coincident with the last lane's last valid output
- overflow  out  LANES  sticky; set by a push while full
- underflow  out  LANES  sticky; set by a scheduled pop while empty

## Operation
- Per lane: circular buffer of DEPTH x DATA_W, plus wr_ptr and rd_ptr (clog2(DEPTH) bits, wrap DEPTH-1 -> 0) and count (CNT_W bits).
- Push: push_en[i] && !full[i] writes push_data[i] at wr_ptr, then wr_ptr++ and count++.
  - push_en[i] && full[i]: data dropped, pointers unchanged, overflow[i] <= 1.
- FSM IDLE -> DRAIN -> IDLE:
  - IDLE: pop_start=1 -> DRAIN with drain_cnt <= 0.
  - DRAIN: drain_cnt++ each cycle. When drain_cnt == DEPTH+LANES-2, return to IDLE on the next edge. pop_start is ignored while in DRAIN.
- Pop schedule: lane i is scheduled in DRAIN cycles where i <= drain_cnt <= i+DEPTH-1.
  - Scheduled and !empty[i]: read at rd_ptr, rd_ptr++, count--. Next cycle out_data[i] = word and out_valid[i] = 1.
  - Scheduled and empty[i]: no pointer change, underflow[i] <= 1. Next cycle out_valid[i] = 0 and out_data[i] = 0.
  - Not scheduled: next cycle out_valid[i] = 0 and out_data[i] = 0.
- Push and pop on the same lane in the same cycle are both performed, and count is unchanged.
  - If the lane was empty at that cycle, the pop sees empty (underflow); there is no write-through.
- Pushes are accepted in every state, including during DRAIN.
- drain_cnt width: $clog2(DEPTH+LANES) bits.
- overflow and underflow clear only on reset.

## Timing
- Reset (edge with rstn=0), applied from any state including mid-drain:
  - state = IDLE; all pointers, counts and drain_cnt = 0.
  - out_data = 0, out_valid = 0, done = 0, overflow = underflow = 0.
  - Resulting outputs: empty = all ones, full = 0, busy = 0.
  - Buffer memory is not cleared.
- Push latency: full/empty reflect a push one cycle after push_en is sampled.
- With pop_start high in cycle C (IDLE), in cycle C+1+k:
  - busy = 1 and drain_cnt = k, for k = 0..DEPTH+LANES-2.
- out_valid[i] is high in cycles C+2+i through C+1+i+DEPTH (DEPTH consecutive cycles), provided the lane held DEPTH entries.
- done is high exactly in cycle C+DEPTH+LANES.
  - busy is already 0 in that cycle.
  - A pop_start in that same cycle is accepted.
- Default parameters: first output at C+2, last output (lane 15) at C+32.

## Test plan
- Fill and drain:
  - Stimulus: push lane i words 16*i+j for j=0..15 over 16 cycles; pulse pop_start at cycle C.
  - Required: lane i emits 16*i+0..16*i+15 in cycles C+2+i..C+17+i; done at C+32; all lanes empty afterwards; no flags set.
- Overflow:
  - Stimulus: push 17 words (1..17) into lane 3.
  - Required: full[3]=1 after the 16th push; overflow[3]=1 after the 17th; drain yields 1..16 and 17 is lost.
- Underflow:
  - Stimulus: push only 10 words into lane 0, then drain.
  - Required: out_valid[0] high for C+2..C+11 and low with out_data=0 for C+12..C+17; underflow[0]=1.
- Simultaneous push/pop:
  - Stimulus: refill lane 5 during its drain window, one word per cycle starting with its first pop.
  - Required: count[5] stays 16; the next drain returns the new words in order.
- Reset mid-drain and ignored start:
  - Stimulus: assert rstn=0 at C+8.
  - Required: next cycle busy=0, out_valid=0, empty all ones. Also, pop_start at C+5 of a separate drain has no effect on timing.
- Back-to-back drains:
  - Stimulus: pop_start at C and again at C+32, with lanes refilled in between.
  - Required: second drain's lane 0 output begins at C+34.
